note_sequencer_ctrl: RTL
========================

// Module: note_sequencer_ctrl
// PURPOSE
//  Parametrised record/playback controller for the note-memory datapath. Records up to DEPTH
//  notes on load_n release, then plays them back at a programmable tempo, once or looped.
//  Drives the memory write and read addresses plus ld_note/ld_play for the datapath.
//  Stop and clear inputs are included.
// PARAMETERS
//  DEPTH     16          note slots; power of two, >=2
//  ADDR_W    $clog2(DEPTH) address width
//  TICK_DIV  25_000_000  clk cycles per note at tempo_sel=0 (0.5 s @ 50 MHz)
//  TEMPO_W   2           tempo_sel width; note period = TICK_DIV >> tempo_sel
// PORTS
//  clk             in   1         system clock
//  reset           in   1         async, active-low
//  load_n          in   1         active-low record key; a note is committed on release (0->1)
//  playback        in   1         active-low play request, level
//  stop_n          in   1         active-low abort of playback
//  clear           in   1         active-high; empties the recording (IDLE only)
//  loop_en         in   1         1: wrap to note 0 after last note
//  tempo_sel       in   TEMPO_W   tempo select, sampled at playback start
//  ld_note         out  1         1 while in LOAD (datapath captures note)
//  ld_play         out  1         1 while in PLAY
//  wr_addr         out  ADDR_W    slot for the note being recorded (= notes_recorded)
//  rd_addr         out  ADDR_W    slot currently playing
//  notes_recorded  out  ADDR_W+1  count 0..DEPTH
//  next_note_en    out  1         1-cycle tempo tick (PLAY only)
//  full            out  1         notes_recorded == DEPTH
//  done            out  1         1-cycle pulse on normal end of a non-loop playback
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; divider cleared; tempo register 0.
//  FSM states: IDLE, LOAD, PLAY. The FSM is registered; outputs decode from the state.
//  - IDLE: load_n=0 & !full -> LOAD. Otherwise, playback=0 & notes_recorded!=0 -> PLAY.
//    Load has priority over playback. load_n=0 while full: stay in IDLE.
//    clear=1 sets notes_recorded=0 next cycle; clear has priority over both transitions.
//  - LOAD: ld_note=1. Stay while load_n=0. On load_n=1: notes_recorded+=1, go to IDLE.
//    Count saturates at DEPTH. clear is ignored in LOAD.
//  - PLAY entry: rd_addr=0, divider restarted, tempo_sel latched.
//    The first note is held for one full period.
//  - PLAY: next_note_en pulses once every (TICK_DIV>>tempo_q) cycles.
//    On a tick with rd_addr < notes_recorded-1: rd_addr+=1.
//    On a tick with rd_addr == notes_recorded-1:
//      loop_en=1: rd_addr=0, stay in PLAY.
//      loop_en=0: go to IDLE and pulse done.
//    loop_en is sampled on each tick. stop_n=0: go to IDLE next cycle, no done pulse.
//    rd_addr holds its last value in IDLE. load_n and clear are ignored in PLAY.
//  - rd_addr is only ever < notes_recorded. ADDR_W arithmetic wraps naturally at DEPTH-1 -> 0.
//  - next_note_en is 0 outside PLAY. The divider is held at reload outside PLAY.
//  - An async reset mid-LOAD discards the pending note. A reset mid-PLAY returns to IDLE.
//    The recording is lost in both cases (count=0).
// STRUCTURE
//  Package note_seq_pkg: state enum (IDLE/LOAD/PLAY), TICK_DIV default,
//  and a helper function for the tempo shift.
//  Sub-module tempo_tick (params TICK_DIV, TEMPO_W; ports clk, reset, restart, en, shift, tick).
//  It is a down-counter that reloads (TICK_DIV>>shift)-1 and pulses tick at 0.
//  This supersedes the fixed 0.5 s divider.
//  Top level: FSM, record counter and read-address counter.
// TESTING (TICK_DIV=8 in bench)
//  1. Reset, then 3 load_n press/release pairs -> notes_recorded=3, wr_addr=3.
//     ld_note is high exactly during each press.
//  2. playback=0, loop_en=0, tempo_sel=0 -> rd_addr steps 0,1,2 at 8-cycle ticks.
//     Then done pulses once, state=IDLE and ld_play=0.
//  3. loop_en=1, tempo_sel=1 -> rd_addr sequence 0,1,2,0,1 at 4-cycle ticks.
//     stop_n=0 -> IDLE next cycle, no done pulse.
//  4. Record 16 notes -> full=1. A 17th press produces no LOAD and the count stays 16.
//     Playback wraps 15->0 with loop_en=1.
//  5. notes_recorded=0 with playback=0 -> stays IDLE.
//     clear in IDLE -> count=0. load_n and playback asserted together -> LOAD wins.
//  6. Assert reset mid-PLAY, asynchronously with no clk edge.
//     -> All outputs 0 immediately. After release, state=IDLE.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types and helpers for the note sequencer controller.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } seq_state_t;

  // Note period at tempo_sel = 0: 0.5 s at 50 MHz.
  localparam int unsigned TICK_DIV_DEFAULT = 25_000_000;

  // Down-counter reload for a given tempo: the period is tick_div >> shift cycles.
  function automatic int unsigned tempo_reload(int unsigned tick_div, int unsigned shift);
    return (tick_div >> shift) - 1;
  endfunction

endpackage

// File: rtl/note_sequencer_ctrl_if.sv
// Control/status bundle between the sequencer controller and its user.
// Protocol: every key input is a level sampled on each clk edge. load_n records a note
// on its 0->1 release, playback (active low) starts a run while held in IDLE,
// stop_n (active low) aborts a run, and clear empties the recording from IDLE.
// Outputs are registered; done and next_note_en are single-cycle pulses.
interface note_sequencer_ctrl_if
  import note_seq_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TEMPO_W = 2
);
  logic               load_n;
  logic               playback;
  logic               stop_n;
  logic               clear;
  logic               loop_en;
  logic [TEMPO_W-1:0] tempo_sel;
  logic               ld_note;
  logic               ld_play;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W:0]    notes_recorded;
  logic               next_note_en;
  logic               full;
  logic               done;
  seq_state_t         state;

  modport master (
    output load_n, playback, stop_n, clear, loop_en, tempo_sel,
    input  ld_note, ld_play, wr_addr, rd_addr, notes_recorded, next_note_en, full, done, state
  );

  modport slave (
    input  load_n, playback, stop_n, clear, loop_en, tempo_sel,
    output ld_note, ld_play, wr_addr, rd_addr, notes_recorded, next_note_en, full, done, state
  );
endinterface

// File: rtl/tempo_tick.sv
// Programmable tempo divider: down-counter that reloads (TICK_DIV >> shift) - 1
// and pulses tick for one cycle when it reaches zero.
module tempo_tick
  import note_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int          TEMPO_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               en,
  input  logic [TEMPO_W-1:0] shift,
  output logic               tick
);
  localparam int CNT_W = $clog2(TICK_DIV + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;

  assign reload = CNT_W'(tempo_reload(TICK_DIV, 32'(shift)));
  assign tick   = en && !restart && (cnt == '0);

  // Hold at reload while idle/restarting, otherwise count down and reload on each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || !en) begin
      cnt <= reload;
    end else if (cnt == '0) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/note_sequencer_ctrl.sv
// Record/playback controller: records up to DEPTH notes on load_n release and
// plays them back at a programmable tempo, once or looped.
module note_sequencer_ctrl
  import note_seq_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int          TEMPO_W  = 2
) (
  input logic                  clk,
  input logic                  reset,
  note_sequencer_ctrl_if.slave bus
);
  seq_state_t         state;
  logic [TEMPO_W-1:0] tempo_q;
  logic [ADDR_W:0]    count;
  logic [ADDR_W-1:0]  rd_addr;
  logic               ld_note;
  logic               ld_play;
  logic               done;
  logic               tick;
  logic               full;
  logic               at_last;
  logic               in_play;
  logic [TEMPO_W-1:0] shift_sel;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign at_last = ({1'b0, rd_addr} == count - (ADDR_W+1)'(1));
  assign in_play = (state == PLAY);
  // Outside PLAY the divider preloads from the live tempo_sel, which is the value
  // latched on entry, so the first note is held for exactly one period.
  assign shift_sel = in_play ? tempo_q : bus.tempo_sel;

  tempo_tick #(
    .TICK_DIV (TICK_DIV),
    .TEMPO_W  (TEMPO_W)
  ) u_tempo_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (!in_play),
    .en      (in_play),
    .shift   (shift_sel),
    .tick    (tick)
  );

  // Controller FSM with record counter, read-address counter and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tempo_q <= '0;
      count   <= '0;
      rd_addr <= '0;
      ld_note <= 1'b0;
      ld_play <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            count   <= '0;
            rd_addr <= '0;
          end else if (!bus.load_n && !full) begin
            state   <= LOAD;
            ld_note <= 1'b1;
          end else if (!bus.playback && (count != '0)) begin
            state   <= PLAY;
            ld_play <= 1'b1;
            rd_addr <= '0;
            tempo_q <= bus.tempo_sel;
          end
        end
        LOAD: begin
          if (bus.load_n) begin
            if (!full) count <= count + (ADDR_W+1)'(1);
            state   <= IDLE;
            ld_note <= 1'b0;
          end
        end
        PLAY: begin
          if (!bus.stop_n) begin
            state   <= IDLE;
            ld_play <= 1'b0;
          end else if (tick) begin
            if (!at_last) begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end else if (bus.loop_en) begin
              rd_addr <= '0;
            end else begin
              state   <= IDLE;
              ld_play <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ld_note <= 1'b0;
          ld_play <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_note        = ld_note;
  assign bus.ld_play        = ld_play;
  assign bus.wr_addr        = count[ADDR_W-1:0];
  assign bus.rd_addr        = rd_addr;
  assign bus.notes_recorded = count;
  assign bus.next_note_en   = tick;
  assign bus.full           = full;
  assign bus.done           = done;
  assign bus.state          = state;
endmodule
